divmod_sched: RTL and testbench

Sequencer between the CPU execute stage and the two integer divide units (32-bit and 64-bit divmod). It accepts one divide command at a time and routes it to the correct unit. It issues a single-cycle `enable` only when that unit reports `can_accept_cmd`, then waits for `data_ready`, latches quotient and remainder, and holds the result until the CPU acknowledges it. It also handles divide-by-zero without touching either unit, supports flushing a command when an interrupt is taken, and counts result latency.

---
 rtl/divmod_sched_pkg.sv | 74 +++++++
 rtl/divmod_sched.sv | 172 +++++++++++++++++
 tb/tb_divmod_sched.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divmod_sched_pkg.sv
// Shared types for the divide sequencer: FSM states, CPU-side port bundles,
// divide-unit command/result bundles and the 32-to-64 result extension rule.
package divmod_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StZero,
      StResp,
      StDrain
   } DivmodSchedState;

   // Saturation point of the result-latency counter
   localparam logic [7:0] CyclesMax = 8'hFF;

   // Command side as seen from the execute stage
   typedef struct packed {
      logic        valid;
      logic        wide;
      logic        sgn;
      logic [63:0] num;
      logic [63:0] denom;
      logic        flush;
      logic        ack;
   } StrcInDivmodSched;

   // Response side as seen from the execute stage
   typedef struct packed {
      logic        ready;
      logic        valid;
      logic [63:0] quot;
      logic [63:0] rem;
      logic        div_zero;
      logic [7:0]  cycles;
      logic        busy;
   } StrcOutDivmodSched;

   // 32-bit divide unit, command and result halves
   typedef struct packed {
      logic        enable;
      logic        unsgn_or_sgn;
      logic [31:0] num;
      logic [31:0] denom;
   } StrcDivmod32Cmd;

   typedef struct packed {
      logic [31:0] quot;
      logic [31:0] rem;
      logic        can_accept_cmd;
      logic        data_ready;
   } StrcDivmod32Res;

   // 64-bit divide unit, command and result halves
   typedef struct packed {
      logic        enable;
      logic        unsgn_or_sgn;
      logic [63:0] num;
      logic [63:0] denom;
   } StrcDivmod64Cmd;

   typedef struct packed {
      logic [63:0] quot;
      logic [63:0] rem;
      logic        can_accept_cmd;
      logic        data_ready;
   } StrcDivmod64Res;

   // Signed results copy bit 31 upward, unsigned results are zero-filled
   function automatic logic [63:0] divmod_extend32(input bit sgn, input bit [31:0] v);
      return sgn ? {{32{v[31]}}, v} : {32'h0000_0000, v};
   endfunction

endpackage

// File: rtl/divmod_sched.sv
// Sequencer between the execute stage and the 32/64-bit divide units.
// Takes one command at a time, issues it to the selected unit once that unit
// can accept it, captures the result and holds it until acknowledged.
// Divide-by-zero is answered locally without touching either unit.
module divmod_sched
   import divmod_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wide,
   input  logic        req_signed,
   input  logic [63:0] req_num,
   input  logic [63:0] req_denom,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ack,
   output logic [63:0] resp_quot,
   output logic [63:0] resp_rem,
   output logic        resp_div_zero,
   output logic [7:0]  resp_cycles,
   output logic        busy,
   output logic        d32_enable,
   output logic        d32_unsgn_or_sgn,
   output logic [31:0] d32_num,
   output logic [31:0] d32_denom,
   input  logic [31:0] d32_quot,
   input  logic [31:0] d32_rem,
   input  logic        d32_can_accept_cmd,
   input  logic        d32_data_ready,
   output logic        d64_enable,
   output logic        d64_unsgn_or_sgn,
   output logic [63:0] d64_num,
   output logic [63:0] d64_denom,
   input  logic [63:0] d64_quot,
   input  logic [63:0] d64_rem,
   input  logic        d64_can_accept_cmd,
   input  logic        d64_data_ready
);

   DivmodSchedState state;

   logic [63:0] num_q;
   logic [63:0] denom_q;
   logic        wide_q;
   logic        signed_q;

   logic        sel_can_accept;
   logic        sel_data_ready;
   logic        issue_fire;
   logic        req_denom_zero;
   logic [63:0] unit_quot;
   logic [63:0] unit_rem;
   logic [63:0] zero_quot;
   logic [63:0] zero_rem;

   // Pick the selected unit's handshake/result and prepare the zero-divide answer
   always_comb begin
      sel_can_accept = wide_q ? d64_can_accept_cmd : d32_can_accept_cmd;
      sel_data_ready = wide_q ? d64_data_ready : d32_data_ready;
      issue_fire     = (state == StIssue) && !flush && sel_can_accept;
      unit_quot      = wide_q ? d64_quot : divmod_extend32(signed_q, d32_quot);
      unit_rem       = wide_q ? d64_rem : divmod_extend32(signed_q, d32_rem);
      zero_quot      = wide_q ? 64'hFFFF_FFFF_FFFF_FFFF
                              : divmod_extend32(signed_q, 32'hFFFF_FFFF);
      zero_rem       = wide_q ? num_q : divmod_extend32(signed_q, num_q[31:0]);
      req_denom_zero = req_wide ? (req_denom == 64'd0) : (req_denom[31:0] == 32'd0);
   end

   // The enable strobe lands in the same cycle the unit reports it can take a
   // command, so a stale can_accept_cmd is never acted on; flush suppresses it
   assign d32_enable       = issue_fire && !wide_q;
   assign d64_enable       = issue_fire && wide_q;
   assign d32_unsgn_or_sgn = signed_q;
   assign d64_unsgn_or_sgn = signed_q;
   assign d32_num          = num_q[31:0];
   assign d32_denom        = denom_q[31:0];
   assign d64_num          = num_q;
   assign d64_denom        = denom_q;

   // Command sequencing, result capture and latency counting
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         req_ready     <= 1'b1;
         busy          <= 1'b0;
         resp_valid    <= 1'b0;
         resp_div_zero <= 1'b0;
         resp_quot     <= 64'd0;
         resp_rem      <= 64'd0;
         resp_cycles   <= 8'd0;
         num_q         <= 64'd0;
         denom_q       <= 64'd0;
         wide_q        <= 1'b0;
         signed_q      <= 1'b0;
      end else begin
         if (((state == StIssue) || (state == StWait)) && (resp_cycles != CyclesMax)) begin
            resp_cycles <= resp_cycles + 8'd1;
         end
         unique case (state)
            StIdle: begin
               if (req_valid && req_ready) begin
                  num_q       <= req_num;
                  denom_q     <= req_denom;
                  wide_q      <= req_wide;
                  signed_q    <= req_signed;
                  resp_cycles <= 8'd0;
                  req_ready   <= 1'b0;
                  busy        <= 1'b1;
                  state       <= req_denom_zero ? StZero : StIssue;
               end
            end
            StIssue: begin
               if (flush) begin
                  state     <= StIdle;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else if (sel_can_accept) begin
                  state <= StWait;
               end
            end
            StWait: begin
               if (flush) begin
                  state <= StDrain;
               end else if (sel_data_ready) begin
                  resp_quot     <= unit_quot;
                  resp_rem      <= unit_rem;
                  resp_div_zero <= 1'b0;
                  resp_valid    <= 1'b1;
                  state         <= StResp;
               end
            end
            StZero: begin
               if (flush) begin
                  state     <= StIdle;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  resp_quot     <= zero_quot;
                  resp_rem      <= zero_rem;
                  resp_div_zero <= 1'b1;
                  resp_valid    <= 1'b1;
                  state         <= StResp;
               end
            end
            StResp: begin
               if (flush || resp_ack) begin
                  resp_valid    <= 1'b0;
                  resp_div_zero <= 1'b0;
                  req_ready     <= 1'b1;
                  busy          <= 1'b0;
                  state         <= StIdle;
               end
            end
            StDrain: begin
               if (sel_data_ready) begin
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: begin
               state     <= StIdle;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divmod_sched.sv
// Self-checking bench for divmod_sched. The bench plays both divide units and
// the execute stage; expected results come from plain integer arithmetic.
module tb_divmod_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wide;
   logic        req_signed;
   logic [63:0] req_num;
   logic [63:0] req_denom;
   logic        flush;
   logic        resp_valid;
   logic        resp_ack;
   logic [63:0] resp_quot;
   logic [63:0] resp_rem;
   logic        resp_div_zero;
   logic [7:0]  resp_cycles;
   logic        busy;
   logic        d32_enable;
   logic        d32_unsgn_or_sgn;
   logic [31:0] d32_num;
   logic [31:0] d32_denom;
   logic [31:0] d32_quot;
   logic [31:0] d32_rem;
   logic        d32_can_accept_cmd;
   logic        d32_data_ready;
   logic        d64_enable;
   logic        d64_unsgn_or_sgn;
   logic [63:0] d64_num;
   logic [63:0] d64_denom;
   logic [63:0] d64_quot;
   logic [63:0] d64_rem;
   logic        d64_can_accept_cmd;
   logic        d64_data_ready;

   int checks_total  = 0;
   int checks_passed = 0;
   int en32_count    = 0;
   int en64_count    = 0;

   divmod_sched dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide),
      .req_signed(req_signed), .req_num(req_num), .req_denom(req_denom),
      .flush(flush), .resp_valid(resp_valid), .resp_ack(resp_ack),
      .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_div_zero(resp_div_zero),
      .resp_cycles(resp_cycles), .busy(busy),
      .d32_enable(d32_enable), .d32_unsgn_or_sgn(d32_unsgn_or_sgn),
      .d32_num(d32_num), .d32_denom(d32_denom), .d32_quot(d32_quot),
      .d32_rem(d32_rem), .d32_can_accept_cmd(d32_can_accept_cmd),
      .d32_data_ready(d32_data_ready),
      .d64_enable(d64_enable), .d64_unsgn_or_sgn(d64_unsgn_or_sgn),
      .d64_num(d64_num), .d64_denom(d64_denom), .d64_quot(d64_quot),
      .d64_rem(d64_rem), .d64_can_accept_cmd(d64_can_accept_cmd),
      .d64_data_ready(d64_data_ready)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Count every enable strobe each unit actually receives
   always @(posedge clk) begin
      if (d32_enable) en32_count <= en32_count + 1;
      if (d64_enable) en64_count <= en64_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Reference divide: truncating integer division, zero divisor gives
   // quotient -1 (all ones of the operation width) and remainder = numerator
   function automatic void refDivmod(input bit wide, input bit sgn, input logic [63:0] n,
                                     input logic [63:0] d, output logic [63:0] q,
                                     output logic [63:0] r);
      longint sn, sd;
      int     sn32, sd32, qi, ri;
      if (wide) begin
         sn = longint'(n);
         sd = longint'(d);
         if (d == 64'd0) begin
            q = 64'hFFFF_FFFF_FFFF_FFFF;
            r = n;
         end else if (sgn) begin
            q = 64'(sn / sd);
            r = 64'(sn % sd);
         end else begin
            q = n / d;
            r = n % d;
         end
      end else if (sgn) begin
         sn32 = int'(n[31:0]);
         sd32 = int'(d[31:0]);
         if (sd32 == 0) begin
            qi = -1;
            ri = sn32;
         end else begin
            qi = sn32 / sd32;
            ri = sn32 % sd32;
         end
         q = 64'(longint'(qi));
         r = 64'(longint'(ri));
      end else begin
         if (d[31:0] == 32'd0) begin
            q = 64'h0000_0000_FFFF_FFFF;
            r = {32'd0, n[31:0]};
         end else begin
            q = {32'd0, n[31:0] / d[31:0]};
            r = {32'd0, n[31:0] % d[31:0]};
         end
      end
   endfunction

   // Selected unit gets the given handshake; the other unit shows constant
   // ready/valid noise that the sequencer must ignore
   task automatic driveUnit(input bit wide, input bit can, input bit rdy,
                            input logic [63:0] q, input logic [63:0] r);
      d32_can_accept_cmd = wide ? 1'b1 : can;
      d32_data_ready     = wide ? 1'b1 : rdy;
      d64_can_accept_cmd = wide ? can : 1'b1;
      d64_data_ready     = wide ? rdy : 1'b1;
      d32_quot = q[31:0];
      d32_rem  = r[31:0];
      d64_quot = q;
      d64_rem  = r;
   endtask

   task automatic offerCmd(input bit wide, input bit sgn, input logic [63:0] num, input logic [63:0] denom);
      req_valid  = 1'b1;
      req_wide   = wide;
      req_signed = sgn;
      req_num    = num;
      req_denom  = denom;
      driveUnit(wide, 1'b0, 1'b0, 64'd0, 64'd0);
      waitCycle();
      req_valid = 1'b0;
      req_num   = {$urandom(), $urandom()};
      req_denom = {$urandom(), $urandom()};
   endtask

   // One complete command: accept, issue after acc_delay blocked cycles,
   // result rdy_delay cycles after enable, ack after ack_delay held cycles
   task automatic applyStimulus(input bit wide, input bit sgn, input logic [63:0] num,
                                input logic [63:0] denom, input int acc_delay,
                                input int rdy_delay, input int ack_delay);
      logic [63:0] exp_q, exp_r, junk;
      bit          zero;
      int          base32, base64, exp_cycles;
      refDivmod(wide, sgn, num, denom, exp_q, exp_r);
      zero       = wide ? (denom == 64'd0) : (denom[31:0] == 32'd0);
      junk       = {$urandom(), $urandom()};
      base32     = en32_count;
      base64     = en64_count;
      exp_cycles = 1 + acc_delay + rdy_delay;
      if (exp_cycles > 255) exp_cycles = 255;
      checkOutput("ready_idle", 64'(req_ready), 64'd1);
      offerCmd(wide, sgn, num, denom);
      checkOutput("ready_dropped", 64'(req_ready), 64'd0);
      checkOutput("busy_accept", 64'(busy), 64'd1);
      if (zero) begin
         checkOutput("zero_no_early_valid", 64'(resp_valid), 64'd0);
         waitCycle();
      end else begin
         for (int k = 0; k < acc_delay; k++) begin
            driveUnit(wide, 1'b0, 1'b0, junk, junk);
            #1;
            checkOutput("enable_waits", 64'(wide ? d64_enable : d32_enable), 64'd0);
            waitCycle();
         end
         driveUnit(wide, 1'b1, 1'b1, junk, ~junk);
         #1;
         checkOutput("enable_pulse", 64'(wide ? d64_enable : d32_enable), 64'd1);
         checkOutput("enable_other", 64'(wide ? d32_enable : d64_enable), 64'd0);
         checkOutput("cmd_num", wide ? d64_num : {32'd0, d32_num}, wide ? num : {32'd0, num[31:0]});
         checkOutput("cmd_denom", wide ? d64_denom : {32'd0, d32_denom}, wide ? denom : {32'd0, denom[31:0]});
         checkOutput("cmd_sign", 64'(wide ? d64_unsgn_or_sgn : d32_unsgn_or_sgn), 64'(sgn));
         waitCycle();
         for (int k = 1; k < rdy_delay; k++) begin
            driveUnit(wide, 1'b0, 1'b0, junk, junk);
            checkOutput("wait_no_valid", 64'(resp_valid), 64'd0);
            waitCycle();
         end
         driveUnit(wide, 1'b0, 1'b1, exp_q, exp_r);
         waitCycle();
         driveUnit(wide, 1'b0, 1'b0, junk, junk);
      end
      checkOutput("resp_valid", 64'(resp_valid), 64'd1);
      checkOutput("resp_quot", resp_quot, exp_q);
      checkOutput("resp_rem", resp_rem, exp_r);
      checkOutput("resp_div_zero", 64'(resp_div_zero), 64'(zero));
      if (!zero) checkOutput("resp_cycles", 64'(resp_cycles), 64'(exp_cycles));
      checkOutput("enables32", 64'(en32_count - base32), 64'(!zero && !wide));
      checkOutput("enables64", 64'(en64_count - base64), 64'(!zero && wide));
      for (int k = 0; k < ack_delay; k++) begin
         waitCycle();
         checkOutput("hold_valid", 64'(resp_valid), 64'd1);
         checkOutput("hold_ready", 64'(req_ready), 64'd0);
         checkOutput("hold_quot", resp_quot, exp_q);
         checkOutput("hold_rem", resp_rem, exp_r);
      end
      resp_ack = 1'b1;
      waitCycle();
      resp_ack = 1'b0;
      checkOutput("ack_valid_clear", 64'(resp_valid), 64'd0);
      checkOutput("ack_ready", 64'(req_ready), 64'd1);
      checkOutput("ack_busy", 64'(busy), 64'd0);
   endtask

   // Directed scenarios followed by a randomized sweep
   initial begin
      logic [63:0] rnum, rdenom;
      bit          rwide, rsgn;
      int          base32;

      rst = 1'b1; req_valid = 1'b0; req_wide = 1'b0; req_signed = 1'b0;
      req_num = 64'd0; req_denom = 64'd0; flush = 1'b0; resp_ack = 1'b0;
      driveUnit(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      waitCycle();
      waitCycle();
      rst = 1'b0;
      waitCycle();
      checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("reset_resp_quot", resp_quot, 64'd0);
      checkOutput("reset_cycles", 64'(resp_cycles), 64'd0);

      applyStimulus(1'b0, 1'b0, 64'd100, 64'd7, 0, 10, 0);
      applyStimulus(1'b1, 1'b1, 64'(-64'sd100), 64'd7, 3, 4, 1);
      applyStimulus(1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 0, 1, 0);
      applyStimulus(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0000_0000, 0, 1, 0);
      applyStimulus(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 1, 1);
      applyStimulus(1'b1, 1'b0, 64'd1000, 64'd3, 0, 2, 20);
      applyStimulus(1'b0, 1'b1, 64'(-64'sd77), 64'd5, 0, 300, 0);

      // Flush while waiting on the unit: result drained, never presented
      base32 = en32_count;
      offerCmd(1'b0, 1'b0, 64'd50, 64'd5);
      driveUnit(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
      waitCycle();
      driveUnit(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      flush = 1'b1;
      waitCycle();
      flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput("drain_busy", 64'(busy), 64'd1);
         checkOutput("drain_no_valid", 64'(resp_valid), 64'd0);
         waitCycle();
      end
      driveUnit(1'b0, 1'b0, 1'b1, 64'd10, 64'd0);
      waitCycle();
      driveUnit(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      checkOutput("drain_done_busy", 64'(busy), 64'd0);
      checkOutput("drain_done_valid", 64'(resp_valid), 64'd0);
      checkOutput("drain_one_enable", 64'(en32_count - base32), 64'd1);
      applyStimulus(1'b0, 1'b0, 64'd77, 64'd8, 1, 2, 0);

      // Flush in the issue cycle wins over can_accept_cmd
      base32 = en32_count;
      offerCmd(1'b0, 1'b0, 64'd9, 64'd3);
      flush = 1'b1;
      driveUnit(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
      #1;
      checkOutput("flush_issue_no_enable", 64'(d32_enable), 64'd0);
      waitCycle();
      flush = 1'b0;
      checkOutput("flush_issue_busy", 64'(busy), 64'd0);
      checkOutput("flush_issue_ready", 64'(req_ready), 64'd1);
      checkOutput("flush_issue_enables", 64'(en32_count - base32), 64'd0);

      // Flush while a result is presented drops it
      offerCmd(1'b1, 1'b1, 64'd5, 64'd0);
      waitCycle();
      checkOutput("flush_resp_valid_before", 64'(resp_valid), 64'd1);
      flush = 1'b1;
      waitCycle();
      flush = 1'b0;
      checkOutput("flush_resp_valid_after", 64'(resp_valid), 64'd0);
      checkOutput("flush_resp_ready", 64'(req_ready), 64'd1);

      // Reset while waiting on the 64-bit unit, then a slow-to-accept unit
      offerCmd(1'b1, 1'b1, 64'd12345, 64'd11);
      driveUnit(1'b1, 1'b1, 1'b0, 64'd0, 64'd0);
      waitCycle();
      driveUnit(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      rst = 1'b1;
      waitCycle();
      rst = 1'b0;
      checkOutput("rst_mid_ready", 64'(req_ready), 64'd1);
      checkOutput("rst_mid_busy", 64'(busy), 64'd0);
      checkOutput("rst_mid_valid", 64'(resp_valid), 64'd0);
      checkOutput("rst_mid_quot", resp_quot, 64'd0);
      checkOutput("rst_mid_rem", resp_rem, 64'd0);
      checkOutput("rst_mid_d64_num", d64_num, 64'd0);
      checkOutput("rst_mid_d64_enable", 64'(d64_enable), 64'd0);
      applyStimulus(1'b1, 1'b1, 64'd12345, 64'd11, 4, 3, 0);

      for (int i = 0; i < 30; i++) begin
         rwide  = 1'($urandom_range(0, 1));
         rsgn   = 1'($urandom_range(0, 1));
         rnum   = {$urandom(), $urandom()};
         case ($urandom_range(0, 5))
            0:       rdenom = {$urandom(), 32'd0};
            1:       rdenom = 64'($urandom_range(1, 1000));
            2:       rdenom = 64'(-64'sd1) - 64'($urandom_range(0, 1000));
            default: rdenom = {$urandom(), $urandom()};
         endcase
         if (rsgn && rwide && rnum == 64'h8000_0000_0000_0000 && rdenom == 64'hFFFF_FFFF_FFFF_FFFF)
            rdenom = 64'd3;
         if (rsgn && !rwide && rnum[31:0] == 32'h8000_0000 && rdenom[31:0] == 32'hFFFF_FFFF)
            rdenom = 64'd3;
         applyStimulus(rwide, rsgn, rnum, rdenom, int'($urandom_range(0, 3)),
                       int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
